// File: rtl/mips_datapath_writeback_stage.sv
// mips_datapath_writeback_stage
//
// Writeback stage that sits directly behind the memory datapath. It registers
// the MEM->WB control on each capture edge. Load data comes from memOut, which
// the memory drives one cycle after the address was presented. That makes it
// valid in the same cycle the instruction sits in WB. The stage picks the
// byte or half lane, extends it, and drives the register-file write port.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   stall               hold all captured state this cycle
//   flush               kill the instruction captured on this edge (ignored while stalled)
//   inValid             memory-stage instruction valid
//   aluResult           ALU result / memory byte address
//   destReg             destination register index
//   regWrite            instruction writes the register file
//   memToReg            1 = write load data, 0 = write aluResult
//   size                00 word, 01 half, 10 byte, 11 word
//   byteExtend          1 = sign-extend, 0 = zero-extend sub-word loads
//   memOut              memory read word (one-cycle latency)
//   outValid            instruction valid in WB
//   wbData, wbReg       register-file write data / index
//   wbWrite             register-file write enable
//   retired             count of instructions retired (wraps)

module mips_datapath_writeback_stage #(
    parameter int REG_W    = 5,
    parameter int COUNT_W  = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               inValid,
    input  logic [31:0]        aluResult,
    input  logic [REG_W-1:0]   destReg,
    input  logic               regWrite,
    input  logic               memToReg,
    input  logic [1:0]         size,
    input  logic               byteExtend,
    input  logic [31:0]        memOut,
    output logic               outValid,
    output logic [31:0]        wbData,
    output logic [REG_W-1:0]   wbReg,
    output logic               wbWrite,
    output logic [COUNT_W-1:0] retired
);

    typedef struct packed {
        logic             valid;
        logic [31:0]      alu;     // also supplies the address low bits for lane select
        logic [REG_W-1:0] dest;
        logic             regWrite;
        logic             memToReg;
        logic [1:0]       size;
        logic             byteExtend;
    } wbState_t;

    wbState_t     st;
    logic [31:0]  holdReg;
    logic         held;

    // memOut is only guaranteed for the single cycle after the address. If the
    // stage stalls, the word is snapshotted on the first stalled edge. It is
    // then served from holdReg until the next capture edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            st      <= '0;
            holdReg <= '0;
            held    <= 1'b0;
            retired <= '0;
        end else begin
            if (!stall) begin
                st <= '{valid:      inValid & ~flush,
                       alu:        aluResult,
                       dest:       destReg,
                       regWrite:   regWrite,
                       memToReg:   memToReg,
                       size:       size,
                       byteExtend: byteExtend};
                held <= 1'b0;
            end else if (!held && st.memToReg) begin
                holdReg <= memOut;
                held    <= 1'b1;
            end

            // An instruction retires on the edge it leaves WB.
            if (st.valid && !stall)
                retired <= retired + COUNT_W'(1);
        end
    end

    logic [31:0] loadWord;
    logic [31:0] extracted;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    assign loadWord = held ? holdReg : memOut;

    // Little-endian lane select: lane 0 is bits 7:0.
    always_comb begin
        byteVal   = loadWord[{st.alu[1:0], 3'b000} +: 8];
        halfVal   = st.alu[1] ? loadWord[31:16] : loadWord[15:0];
        extracted = loadWord;
        case (st.size)
            2'b10:   extracted = {{24{st.byteExtend & byteVal[7]}}, byteVal};
            2'b01:   extracted = {{16{st.byteExtend & halfVal[15]}}, halfVal};
            default: extracted = loadWord;
        endcase
    end

    logic zeroBlocked;
    assign zeroBlocked = ZERO_REG && (st.dest == '0);

    assign outValid = st.valid;
    assign wbReg    = st.dest;
    assign wbData   = !st.valid ? 32'h0 : (st.memToReg ? extracted : st.alu);
    assign wbWrite  = st.valid & st.regWrite & ~zeroBlocked;

endmodule

// File: tb/tb_mips_datapath_writeback_stage.sv
module tb_mips_datapath_writeback_stage;

    logic        clock = 1'b0;
    logic        reset, stall, flush, inValid, regWrite, memToReg, byteExtend;
    logic [31:0] aluResult, memOut;
    logic [4:0]  destReg;
    logic [1:0]  size;
    logic        outValid, wbWrite;
    logic [31:0] wbData;
    logic [4:0]  wbReg;
    logic [3:0]  retired;

    mips_datapath_writeback_stage #(.REG_W(5), .COUNT_W(4), .ZERO_REG(1'b1)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .inValid(inValid), .aluResult(aluResult), .destReg(destReg),
        .regWrite(regWrite), .memToReg(memToReg), .size(size),
        .byteExtend(byteExtend), .memOut(memOut), .outValid(outValid),
        .wbData(wbData), .wbReg(wbReg), .wbWrite(wbWrite), .retired(retired)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          v;
        logic [31:0] d;
        logic [4:0]  r;
        bit          w;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    bit   vModel = 0;   // expected valid in WB
    int   retModel = 0;

    function automatic exp_t predict(bit v, bit [31:0] alu, bit [4:0] rd, bit rw,
                                     bit m2r, bit [1:0] sz, bit ext, bit [31:0] word);
        exp_t x;
        bit [31:0] sh;
        bit [31:0] ld;
        case (sz)
            2'b10: begin
                sh = word >> (32'(alu[1:0]) * 8);
                ld = {24'h0, sh[7:0]};
                if (ext && sh[7]) ld = ld | 32'hFFFF_FF00;
            end
            2'b01: begin
                sh = alu[1] ? (word >> 16) : word;
                ld = {16'h0, sh[15:0]};
                if (ext && sh[15]) ld = ld | 32'hFFFF_0000;
            end
            default: ld = word;
        endcase
        x.v = v;
        x.d = !v ? 32'h0 : (m2r ? ld : alu);
        x.r = rd;
        x.w = v && rw && (rd != 0);
        return x;
    endfunction

    task automatic setIn(bit v, bit [31:0] alu, bit [4:0] rd, bit rw, bit m2r,
                         bit [1:0] sz, bit ext, bit fl, bit st);
        inValid = v; aluResult = alu; destReg = rd; regWrite = rw; memToReg = m2r;
        size = sz; byteExtend = ext; flush = fl; stall = st;
    endtask

    // One clock edge: update the reference valid/retire model from the inputs
    // being presented, then drive this cycle's memory word after the edge.
    task automatic tick(bit [31:0] mem);
        if (reset) begin
            vModel = 0; retModel = 0;
        end else begin
            if (vModel && !stall) retModel = (retModel + 1) % 16;
            if (!stall) vModel = inValid & ~flush;
        end
        @(posedge clock);
        #1 memOut = mem;
        @(negedge clock);
    endtask

    task automatic test_reset;
        reset = 1;
        setIn(1, 32'h1234, 5'd3, 1, 0, 0, 0, 0, 0);
        tick(32'hFFFF_FFFF);
        tick(32'hFFFF_FFFF);
        checks++;
        if (outValid !== 1'b0 || wbWrite !== 1'b0 || wbData !== 32'h0 || wbReg !== 5'd0) begin
            errors++;
            $display("FAIL reset_outputs got v=%b w=%b d=%h r=%0d exp all zero",
                     outValid, wbWrite, wbData, wbReg);
        end
        checks++;
        if (retired !== 4'd0) begin
            errors++; $display("FAIL reset_retired got %0d exp 0", retired);
        end
        reset = 0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h0);
    endtask

    task automatic test_byte;
        setIn(1, 32'h1003, 5'd7, 1, 1, 2'b10, 1, 0, 0);
        sb.push_back(predict(1, 32'h1003, 7, 1, 1, 2'b10, 1, 32'h80FF_1234));
        tick(32'h80FF_1234);
        e = sb.pop_front();
        checks++;
        if (wbData !== e.d || e.d !== 32'hFFFF_FF80) begin
            errors++; $display("FAIL byte_sext got %h exp %h", wbData, 32'hFFFF_FF80);
        end
        checks++;
        if (wbWrite !== e.w || wbReg !== e.r) begin
            errors++; $display("FAIL byte_port got w=%b r=%0d exp w=%b r=%0d", wbWrite, wbReg, e.w, e.r);
        end
        setIn(1, 32'h1003, 5'd7, 1, 1, 2'b10, 0, 0, 0);
        sb.push_back(predict(1, 32'h1003, 7, 1, 1, 2'b10, 0, 32'h80FF_1234));
        tick(32'h80FF_1234);
        e = sb.pop_front();
        checks++;
        if (wbData !== e.d || e.d !== 32'h0000_0080) begin
            errors++; $display("FAIL byte_zext got %h exp %h", wbData, 32'h0000_0080);
        end
        // byte lanes 0..2 back to back, alternating extension
        for (int i = 0; i < 3; i++) begin
            setIn(1, 32'h5000 + i, 5'd8, 1, 1, 2'b10, i[0], 0, 0);
            sb.push_back(predict(1, 32'h5000 + i, 8, 1, 1, 2'b10, i[0], 32'hC3A5_F00F));
            tick(32'hC3A5_F00F);
            e = sb.pop_front();
            checks++;
            if (wbData !== e.d) begin
                errors++; $display("FAIL byte_lane%0d got %h exp %h", i, wbData, e.d);
            end
        end
    endtask

    task automatic test_half;
        setIn(1, 32'h2002, 5'd10, 1, 1, 2'b01, 1, 0, 0);
        sb.push_back(predict(1, 32'h2002, 10, 1, 1, 2'b01, 1, 32'h9ABC_0000));
        tick(32'h9ABC_0000);
        e = sb.pop_front();
        checks++;
        if (wbData !== e.d || e.d !== 32'hFFFF_9ABC) begin
            errors++; $display("FAIL half_sext got %h exp %h", wbData, 32'hFFFF_9ABC);
        end
        setIn(1, 32'h2002, 5'd10, 1, 1, 2'b11, 1, 0, 0);
        sb.push_back(predict(1, 32'h2002, 10, 1, 1, 2'b11, 1, 32'h9ABC_0000));
        tick(32'h9ABC_0000);
        e = sb.pop_front();
        checks++;
        if (wbData !== e.d || e.d !== 32'h9ABC_0000) begin
            errors++; $display("FAIL half_size11 got %h exp %h", wbData, 32'h9ABC_0000);
        end
        // low half, bit 0 set (ignored), zero-extend
        setIn(1, 32'h2001, 5'd10, 1, 1, 2'b01, 0, 0, 0);
        sb.push_back(predict(1, 32'h2001, 10, 1, 1, 2'b01, 0, 32'h1111_8765));
        tick(32'h1111_8765);
        e = sb.pop_front();
        checks++;
        if (wbData !== e.d) begin
            errors++; $display("FAIL half_low got %h exp %h", wbData, e.d);
        end
    endtask

    task automatic test_stall_hold;
        int retBefore;
        setIn(1, 32'h3000, 5'd9, 1, 1, 2'b00, 0, 0, 0);
        sb.push_back(predict(1, 32'h3000, 9, 1, 1, 2'b00, 0, 32'hDEAD_BEEF));
        tick(32'hDEAD_BEEF);
        e = sb.pop_front();
        checks++;
        if (wbData !== e.d) begin
            errors++; $display("FAIL hold_first got %h exp %h", wbData, e.d);
        end
        retBefore = retModel;
        // garbage on the inputs while stalled must not be captured
        setIn(1, 32'h4444, 5'd3, 0, 0, 2'b10, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            sb.push_back(e);
            tick(32'h0);
            e = sb.pop_front();
            checks++;
            if (wbData !== e.d || wbReg !== e.r || wbWrite !== e.w) begin
                errors++;
                $display("FAIL hold_stall%0d got d=%h r=%0d w=%b exp d=%h r=%0d w=%b",
                         i, wbData, wbReg, wbWrite, e.d, e.r, e.w);
            end
            checks++;
            if (retired !== 4'(retBefore)) begin
                errors++; $display("FAIL hold_retired%0d got %0d exp %0d", i, retired, retBefore);
            end
        end
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h0);
        checks++;
        if (retired !== 4'((retBefore + 1) % 16) || outValid !== 1'b0) begin
            errors++; $display("FAIL hold_release got ret=%0d v=%b exp ret=%0d v=0",
                               retired, outValid, (retBefore + 1) % 16);
        end
    endtask

    task automatic test_flush_zero;
        setIn(1, 32'h55, 5'd4, 1, 0, 0, 0, 1, 0);
        sb.push_back(predict(0, 32'h55, 4, 1, 0, 0, 0, 32'h0));
        tick(32'h0);
        e = sb.pop_front();
        checks++;
        if (outValid !== e.v || wbWrite !== e.w || wbData !== e.d) begin
            errors++; $display("FAIL flush_kill got v=%b w=%b d=%h exp v=0 w=0 d=0", outValid, wbWrite, wbData);
        end
        setIn(1, 32'h1234, 5'd0, 1, 0, 0, 0, 0, 0);
        sb.push_back(predict(1, 32'h1234, 0, 1, 0, 0, 0, 32'h0));
        tick(32'h0);
        e = sb.pop_front();
        checks++;
        if (outValid !== 1'b1 || wbWrite !== e.w || wbData !== e.d) begin
            errors++; $display("FAIL zero_reg got v=%b w=%b d=%h exp v=1 w=%b d=%h",
                               outValid, wbWrite, wbData, e.w, e.d);
        end
        setIn(1, 32'h77, 5'd6, 1, 0, 0, 0, 0, 0);
        sb.push_back(predict(1, 32'h77, 6, 1, 0, 0, 0, 32'h0));
        tick(32'h0);
        e = sb.pop_front();
        setIn(1, 32'h99, 5'd2, 1, 0, 0, 0, 1, 1);
        sb.push_back(e);
        tick(32'h0);
        e = sb.pop_front();
        checks++;
        if (outValid !== 1'b1 || wbData !== e.d || wbReg !== e.r || wbWrite !== e.w) begin
            errors++; $display("FAIL flush_stall got v=%b d=%h r=%0d w=%b exp v=1 d=%h r=%0d w=%b",
                               outValid, wbData, wbReg, wbWrite, e.d, e.r, e.w);
        end
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h0);
        checks++;
        if (retired !== 4'(retModel)) begin
            errors++; $display("FAIL flush_retired got %0d exp %0d", retired, retModel);
        end
    endtask

    task automatic test_reset_mid_load;
        setIn(1, 32'h6000, 5'd12, 1, 1, 2'b00, 0, 0, 0);
        tick(32'hCAFE_F00D);
        reset = 1;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'hCAFE_F00D);
        reset = 0;
        checks++;
        if (outValid !== 1'b0 || wbWrite !== 1'b0 || retired !== 4'd0 || wbData !== 32'h0) begin
            errors++; $display("FAIL reset_mid_load got v=%b w=%b ret=%0d d=%h exp 0 0 0 0",
                               outValid, wbWrite, retired, wbData);
        end
    endtask

    task automatic test_back_to_back;
        bit [31:0] a;
        for (int i = 0; i < 17; i++) begin
            a = $urandom;
            setIn(1, a, 5'(i + 1), 1, 0, 0, 0, 0, 0);
            sb.push_back(predict(1, a, 5'(i + 1), 1, 0, 0, 0, 32'h0));
            tick(32'h0);
            e = sb.pop_front();
            checks++;
            if (wbData !== e.d || wbReg !== e.r || wbWrite !== e.w) begin
                errors++; $display("FAIL b2b_%0d got d=%h r=%0d w=%b exp d=%h r=%0d w=%b",
                                   i, wbData, wbReg, wbWrite, e.d, e.r, e.w);
            end
        end
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(32'h0);
        checks++;
        if (retired !== 4'd1 || retModel != 1) begin
            errors++; $display("FAIL counter_wrap got %0d exp 1", retired);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; memOut = 0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset;
        test_byte;
        test_half;
        test_stall_hold;
        test_flush_zero;
        test_reset_mid_load;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
